// File: rtl/verilated_stream_fixtures.sv
// Valid/ready stream fixture: a burst source that emits a running sequence and a
// sink that checks harness-driven beats against that same sequence.
module verilated_stream_fixtures #(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 16
) (
  input  logic             clk,
  input  logic             sync_rst,
  input  logic             start,
  output logic             src_valid,
  input  logic             src_ready,
  output logic [WIDTH-1:0] src_data,
  output logic             src_last,
  input  logic             snk_valid,
  output logic             snk_ready,
  input  logic [WIDTH-1:0] snk_data,
  input  logic             snk_last,
  input  logic             snk_stall,
  output logic             busy,
  output logic [15:0]      beats_sent,
  output logic [15:0]      beats_recv,
  output logic             error,
  output logic [7:0]       err_count
);

  localparam int IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);

  typedef enum logic {IDLE, SEND} src_state_t;

  src_state_t       state, state_next;
  logic [WIDTH-1:0] seq;
  logic [IDX_W-1:0] src_idx;
  logic             src_hs;
  logic             src_at_last;

  logic [WIDTH-1:0] exp_data;
  logic [IDX_W-1:0] snk_idx;
  logic             snk_hs;
  logic             snk_idx_last;
  logic             beat_bad;

  assign src_at_last = (src_idx == LAST_IDX);
  assign src_hs      = src_valid && src_ready;

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // start is only honoured in IDLE, so a start held over the last-beat edge is dropped
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SEND;
      SEND:    if (src_hs && src_at_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    src_valid = (state == SEND);
    busy      = (state == SEND);
    src_last  = (state == SEND) && src_at_last;
    src_data  = seq;
  end

  // Sequence counter persists across bursts; only the beat index restarts
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      seq        <= '0;
      src_idx    <= '0;
      beats_sent <= '0;
    end else if (src_hs) begin
      seq        <= seq + WIDTH'(1);
      src_idx    <= src_at_last ? '0 : src_idx + IDX_W'(1);
      beats_sent <= beats_sent + 16'd1;
    end
  end

  assign snk_hs       = snk_valid && snk_ready;
  assign snk_idx_last = (snk_idx == LAST_IDX);
  assign beat_bad     = (snk_data != exp_data) || (snk_last != snk_idx_last);

  // Expected value follows the received data so a single glitch costs one error
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      snk_ready  <= 1'b0;
      exp_data   <= '0;
      snk_idx    <= '0;
      beats_recv <= '0;
      error      <= 1'b0;
      err_count  <= '0;
    end else begin
      snk_ready <= !snk_stall;
      if (snk_hs) begin
        exp_data   <= snk_data + WIDTH'(1);
        beats_recv <= beats_recv + 16'd1;
        if (snk_last || snk_idx_last) begin
          snk_idx <= '0;
        end else begin
          snk_idx <= snk_idx + IDX_W'(1);
        end
        if (beat_bad) begin
          error <= 1'b1;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_verilated_stream_fixtures.sv
// Directed bench for verilated_stream_fixtures: source bursts, backpressure,
// loopback, sink error rules, mid-burst reset and a 4-bit wrap instance.
module tb_verilated_stream_fixtures;

  logic        clk = 1'b0;
  logic        sync_rst, start, src_ready_d, snk_valid_d, snk_last_d, snk_stall;
  logic [7:0]  snk_data_d;
  logic        loop_mode;
  logic        src_valid, src_last, snk_ready, busy, error;
  logic [7:0]  src_data, err_count;
  logic [15:0] beats_sent, beats_recv;
  logic        src_ready_w, snk_valid_w, snk_last_w;
  logic [7:0]  snk_data_w;

  logic        rst4, start4, src_valid4, src_last4, snk_ready4, busy4, error4;
  logic [3:0]  src_data4;
  logic [15:0] beats_sent4, beats_recv4;
  logic [7:0]  err_count4;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  assign src_ready_w = loop_mode ? snk_ready : src_ready_d;
  assign snk_valid_w = loop_mode ? src_valid : snk_valid_d;
  assign snk_data_w  = loop_mode ? src_data  : snk_data_d;
  assign snk_last_w  = loop_mode ? src_last  : snk_last_d;

  verilated_stream_fixtures #(.WIDTH(8), .BURST_LEN(16)) dut (
    .clk(clk), .sync_rst(sync_rst), .start(start),
    .src_valid(src_valid), .src_ready(src_ready_w), .src_data(src_data), .src_last(src_last),
    .snk_valid(snk_valid_w), .snk_ready(snk_ready), .snk_data(snk_data_w), .snk_last(snk_last_w),
    .snk_stall(snk_stall), .busy(busy), .beats_sent(beats_sent), .beats_recv(beats_recv),
    .error(error), .err_count(err_count)
  );

  // 4-bit instance permanently looped source->sink to exercise data wrap
  verilated_stream_fixtures #(.WIDTH(4), .BURST_LEN(16)) dut4 (
    .clk(clk), .sync_rst(rst4), .start(start4),
    .src_valid(src_valid4), .src_ready(snk_ready4), .src_data(src_data4), .src_last(src_last4),
    .snk_valid(src_valid4), .snk_ready(snk_ready4), .snk_data(src_data4), .snk_last(src_last4),
    .snk_stall(1'b0), .busy(busy4), .beats_sent(beats_sent4), .beats_recv(beats_recv4),
    .error(error4), .err_count(err_count4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    sync_rst = 1'b1;
    repeat (n) tick();
    sync_rst = 1'b0;
  endtask

  task automatic send_snk(input logic [7:0] d, input logic l);
    snk_valid_d = 1'b1;
    snk_data_d  = d;
    snk_last_d  = l;
    tick();
    snk_valid_d = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(2);
    tests_run++; if (src_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_src_valid got %0b want 0", src_valid); end
    tests_run++; if (src_data !== 8'd0) begin tests_failed++; $display("[TB] FAIL reset_src_data got %0d want 0", src_data); end
    tests_run++; if (src_last !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_src_last got %0b want 0", src_last); end
    tests_run++; if (snk_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_snk_ready got %0b want 0", snk_ready); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy got %0b want 0", busy); end
    tests_run++; if (beats_sent !== 16'd0 || beats_recv !== 16'd0) begin tests_failed++; $display("[TB] FAIL reset_beats got %0d/%0d want 0/0", beats_sent, beats_recv); end
    tests_run++; if (error !== 1'b0 || err_count !== 8'd0) begin tests_failed++; $display("[TB] FAIL reset_error got %0b/%0d want 0/0", error, err_count); end
  endtask

  task automatic test_burst();
    src_ready_d = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tests_run++; if (src_valid !== 1'b1 || busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL burst_valid beat %0d got %0b/%0b want 1/1", i, src_valid, busy); end
      tests_run++; if (src_data !== 8'(i)) begin tests_failed++; $display("[TB] FAIL burst_data got %0d want %0d", src_data, i); end
      tests_run++; if (src_last !== (i == 15)) begin tests_failed++; $display("[TB] FAIL burst_last beat %0d got %0b want %0b", i, src_last, (i == 15)); end
      tick();
    end
    tests_run++; if (src_valid !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL burst_end_valid got %0b/%0b want 0/0", src_valid, busy); end
    tests_run++; if (beats_sent !== 16'd16) begin tests_failed++; $display("[TB] FAIL burst_beats_sent got %0d want 16", beats_sent); end
  endtask

  // start is held high through the whole second burst, including the last edge
  task automatic test_back_to_back();
    start = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      tests_run++; if (src_valid !== 1'b1 || src_data !== 8'(16 + i)) begin tests_failed++; $display("[TB] FAIL b2b_data got %0b/%0d want 1/%0d", src_valid, src_data, 16 + i); end
      tick();
    end
    start = 1'b0;
    tests_run++; if (src_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_start_ignored got valid %0b want 0", src_valid); end
    tests_run++; if (beats_sent !== 16'd32) begin tests_failed++; $display("[TB] FAIL b2b_beats_sent got %0d want 32", beats_sent); end
  endtask

  task automatic test_backpressure();
    int exp_v;
    int cyc;
    do_reset(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_v = 0;
    cyc = 0;
    while (exp_v < 16 && cyc < 100) begin
      src_ready_d = (cyc % 2 == 0);
      tests_run++; if (src_valid !== 1'b1 || src_data !== 8'(exp_v)) begin tests_failed++; $display("[TB] FAIL bp_hold got %0b/%0d want 1/%0d", src_valid, src_data, exp_v); end
      tests_run++; if (src_last !== (exp_v == 15)) begin tests_failed++; $display("[TB] FAIL bp_last data %0d got %0b want %0b", exp_v, src_last, (exp_v == 15)); end
      if (src_ready_d) exp_v++;
      tick();
      cyc++;
    end
    tests_run++; if (exp_v != 16) begin tests_failed++; $display("[TB] FAIL bp_timeout got %0d beats want 16", exp_v); end
    tests_run++; if (src_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_end_valid got %0b want 0", src_valid); end
    src_ready_d = 1'b1;
  endtask

  task automatic test_loopback();
    int bursts;
    int cyc;
    do_reset(1);
    loop_mode = 1'b1;
    bursts = 0;
    cyc = 0;
    while (beats_recv < 16'd32 && cyc < 600) begin
      snk_stall = 1'($urandom_range(0, 1));
      start = (!busy && bursts < 2);
      if (start) bursts++;
      tick();
      cyc++;
    end
    start = 1'b0;
    snk_stall = 1'b0;
    tests_run++; if (beats_recv !== 16'd32) begin tests_failed++; $display("[TB] FAIL loop_beats_recv got %0d want 32", beats_recv); end
    tests_run++; if (beats_sent !== 16'd32) begin tests_failed++; $display("[TB] FAIL loop_beats_sent got %0d want 32", beats_sent); end
    tests_run++; if (error !== 1'b0 || err_count !== 8'd0) begin tests_failed++; $display("[TB] FAIL loop_errors got %0b/%0d want 0/0", error, err_count); end
    loop_mode = 1'b0;
  endtask

  task automatic test_sink_errors();
    do_reset(1);
    snk_stall = 1'b0;
    tick();
    snk_stall = 1'b1;
    tests_run++; if (snk_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL stall_latency_pre got %0b want 1", snk_ready); end
    tick();
    tests_run++; if (snk_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_latency_post got %0b want 0", snk_ready); end
    snk_stall = 1'b0;
    tick();
    send_snk(8'd0, 1'b0);
    send_snk(8'd1, 1'b0);
    tests_run++; if (err_count !== 8'd0 || error !== 1'b0) begin tests_failed++; $display("[TB] FAIL snk_clean got %0d/%0b want 0/0", err_count, error); end
    send_snk(8'd5, 1'b0);
    tests_run++; if (err_count !== 8'd1 || error !== 1'b1) begin tests_failed++; $display("[TB] FAIL snk_data_err got %0d/%0b want 1/1", err_count, error); end
    send_snk(8'd6, 1'b0);
    tests_run++; if (err_count !== 8'd1) begin tests_failed++; $display("[TB] FAIL snk_resync got %0d want 1", err_count); end
    send_snk(8'd7, 1'b1);
    tests_run++; if (err_count !== 8'd2) begin tests_failed++; $display("[TB] FAIL snk_early_last got %0d want 2", err_count); end
    for (int i = 0; i < 16; i++) send_snk(8'(8 + i), (i == 15));
    tests_run++; if (err_count !== 8'd2) begin tests_failed++; $display("[TB] FAIL snk_index_restart got %0d want 2", err_count); end
    send_snk(8'd100, 1'b1);
    tests_run++; if (err_count !== 8'd3) begin tests_failed++; $display("[TB] FAIL snk_double_fault got %0d want 3", err_count); end
    tests_run++; if (beats_recv !== 16'd22) begin tests_failed++; $display("[TB] FAIL snk_beats_recv got %0d want 22", beats_recv); end
  endtask

  task automatic test_mid_reset();
    do_reset(1);
    src_ready_d = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    tests_run++; if (src_data !== 8'd7 || src_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL midrst_pre got %0b/%0d want 1/7", src_valid, src_data); end
    sync_rst = 1'b1;
    tick();
    sync_rst = 1'b0;
    tests_run++; if (src_valid !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_valid got %0b/%0b want 0/0", src_valid, busy); end
    tests_run++; if (beats_sent !== 16'd0 || src_data !== 8'd0) begin tests_failed++; $display("[TB] FAIL midrst_counters got %0d/%0d want 0/0", beats_sent, src_data); end
    start = 1'b1;
    tick();
    start = 1'b0;
    tests_run++; if (src_valid !== 1'b1 || src_data !== 8'd0) begin tests_failed++; $display("[TB] FAIL midrst_restart got %0b/%0d want 1/0", src_valid, src_data); end
  endtask

  task automatic test_wrap_width4();
    int count;
    int bursts;
    int cyc;
    rst4 = 1'b1;
    repeat (2) tick();
    rst4 = 1'b0;
    count = 0;
    bursts = 0;
    cyc = 0;
    while (count < 32 && cyc < 200) begin
      start4 = (!busy4 && bursts < 2);
      if (start4) bursts++;
      if (src_valid4 && snk_ready4) begin
        tests_run++; if (src_data4 !== 4'(count)) begin tests_failed++; $display("[TB] FAIL w4_data beat %0d got %0d want %0d", count, src_data4, count % 16); end
        count++;
      end
      tick();
      cyc++;
    end
    start4 = 1'b0;
    tests_run++; if (beats_recv4 !== 16'd32) begin tests_failed++; $display("[TB] FAIL w4_beats_recv got %0d want 32", beats_recv4); end
    tests_run++; if (error4 !== 1'b0 || err_count4 !== 8'd0) begin tests_failed++; $display("[TB] FAIL w4_errors got %0b/%0d want 0/0", error4, err_count4); end
  endtask

  initial begin
    sync_rst = 1'b0; start = 1'b0; src_ready_d = 1'b0; snk_valid_d = 1'b0;
    snk_last_d = 1'b0; snk_data_d = 8'd0; snk_stall = 1'b0; loop_mode = 1'b0;
    rst4 = 1'b1; start4 = 1'b0;
    #1;
    test_reset();
    test_burst();
    test_back_to_back();
    test_backpressure();
    test_loopback();
    test_sink_errors();
    test_mid_reset();
    test_wrap_width4();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
